multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Main control FSM for the 16-bit multi-cycle CPU datapath (PC, IR, register file, ALU, ALUOut, shared instruction/data memory).
- Sequences each instruction through fetch/decode/execute/memory/writeback states.
- Drives every datapath enable and mux select, and waits on a memory-ready handshake.
- Keeps cycle and retired-instruction counters for debug output.

Parameters:
- CNT_W, 16, width of cycle_count and instr_count (wrap-around counters)

Ports:
- clock  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; state returns to FETCH and counters clear
- opcode  in  4  IR[15:12] of the current instruction
- zero  in  1  ALU zero flag (combinational from datapath)
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  PC load enable
- ir_write  out  1  IR load enable
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- reg_write  out  1  register file write enable
- reg_dst  out  1  write register: 0 = rt, 1 = rd
- mem_to_reg  out  1  writeback data: 0 = ALUOut, 1 = MDR
- alu_src_a  out  1  ALU A input: 0 = PC, 1 = reg A
- alu_src_b  out  2  ALU B input: 00 = reg B, 01 = constant 1, 10 = sign-extended imm, 11 = zero
- alu_op  out  3  000 = ADD, 001 = SUB, 010 = FUNCT (R-type decode); others unused
- pc_source  out  2  PC input: 00 = ALU result, 01 = ALUOut, 10 = jump target
- illegal_op  out  1  one-cycle pulse on an undefined opcode
- halted  out  1  high while in HALT
- state_out  out  4  current state encoding (debug)
- cycle_count  out  CNT_W  clock cycles since reset
- instr_count  out  CNT_W  retired instructions since reset

Behaviour:
- Opcodes:
  - 0 R-type; 1 ADDI; 2 LW; 3 SW; 4 BEQ; 5 BNE; 6 J; 7 HALT.
  - Opcodes 8-15 are illegal.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, HALT=11.
- Outputs are Moore-decoded from the state register. Any signal not listed for a state is 0.
- While reset=1, all write/request strobes are forced to 0.
- Reset: state=FETCH, cycle_count=0, instr_count=0, halted=0, illegal_op=0.
- FETCH:
  - Drives mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_source=00.
  - ir_write and pc_write are asserted only when mem_ready=1.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=10, alu_op=ADD (branch target into ALUOut). Next state by opcode:
  - 0 -> EXEC; 1 -> ADDIEX; 2, 3 -> MEMADR; 4, 5 -> BRANCH; 6 -> JUMP; 7 -> HALT.
  - 8-15 -> FETCH, with illegal_op=1 for this cycle only.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=ADD. Goes to MEMRD for LW, MEMWR for SW.
- MEMRD: mem_read=1, iord=1. Holds until mem_ready=1, then goes to MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1. Goes to FETCH.
- MEMWR:
  - mem_write=1, iord=1; holds while mem_ready=0.
  - mem_write stays high for the whole wait.
  - Goes to FETCH on mem_ready=1.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=FUNCT. Goes to ALUWB.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=ADD. Goes to ALUWB.
- ALUWB: reg_write=1, mem_to_reg=0; reg_dst=1 if the latched opcode is 0, else 0. Goes to FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_source=01.
  - pc_write = (opcode==4 & zero) | (opcode==5 & ~zero).
  - Goes to FETCH.
- JUMP: pc_source=10, pc_write=1. Goes to FETCH.
- HALT: halted=1, all strobes 0. Stays in HALT until reset.
- opcode is sampled combinationally each cycle. The IR holds it stable after FETCH; the FSM does not latch it.
- instr_count: increments by 1 on every transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH or JUMP, and once on entry to HALT.
  - Illegal opcodes do not increment it.
- cycle_count: increments every cycle with reset=0, including HALT and memory waits.
- Both counters wrap from 2^CNT_W-1 to 0.
- Latencies with mem_ready tied high:
  - R/ADDI/SW = 4 cycles; LW = 5; BEQ/BNE/J = 3; illegal = 2.
- Reset asserted in any state, including mid-wait in MEMWR: the next state is FETCH and no write strobe is asserted in the reset cycle.

Test Plan:
- Reset for 5 cycles, then release with mem_ready=1 and opcode=0: states 0,1,6,7,0; reg_write=1 and reg_dst=1 only in state 7; instr_count=1 after 4 cycles.
- LW (opcode=2) with mem_ready low for 3 cycles in MEMRD: state sequence 0,1,2,3,3,3,3,4,0; mem_read held high throughout MEMRD; mem_to_reg=1 in state 4.
- BEQ (opcode=4): zero=1 gives pc_write=1 in BRANCH; zero=0 gives pc_write=0. BNE (opcode=5) gives the inverse. Each takes 3 cycles and increments instr_count.
- opcode=9 in DECODE: illegal_op pulses exactly 1 cycle; returns to FETCH; instr_count unchanged; cycle_count +2.
- opcode=7: halted=1 and state_out=11 held for 20 cycles with all strobes 0; instr_count +1 only once; cycle_count keeps incrementing; reset returns to FETCH.
- Reset asserted during MEMWR with mem_ready=0: mem_write=0 in the reset cycle; state=0 and counters=0 the next cycle.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control/datapath bundle for the multi-cycle CPU controller.
// master = controller side, slave = datapath side.
interface multicycle_control_if #(parameter int CNT_W = 16);
  logic [3:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             pc_write;
  logic             ir_write;
  logic             iord;
  logic             mem_read;
  logic             mem_write;
  logic             reg_write;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [2:0]       alu_op;
  logic [1:0]       pc_source;
  logic             illegal_op;
  logic             halted;
  logic [3:0]       state_out;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, ir_write, iord, mem_read, mem_write, reg_write, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op,
           halted, state_out, cycle_count, instr_count
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, ir_write, iord, mem_read, mem_write, reg_write, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op,
           halted, state_out, cycle_count, instr_count
  );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM for the 16-bit multi-cycle CPU: sequences fetch/decode/
// execute/memory/writeback, drives datapath controls, keeps debug counters.
module multicycle_control #(
  parameter int CNT_W = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  ALUWB = 4'd7,
    BRANCH = 4'd8,  JUMP   = 4'd9,  ADDIEX = 4'd10, HALT  = 4'd11
  } state_t;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;

  state_t           state;
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] instr_q;
  logic             retire;

  // An instruction retires on its last cycle before FETCH, or on entering HALT.
  always_comb begin
    retire = 1'b0;
    case (state)
      MEMWB, ALUWB, BRANCH, JUMP: retire = 1'b1;
      MEMWR:                      retire = bus.mem_ready;
      DECODE:                     retire = (bus.opcode == 4'd7);
      default:                    retire = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= FETCH;
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      cycle_q <= cycle_q + 1'b1;
      if (retire) instr_q <= instr_q + 1'b1;
      case (state)
        FETCH:  if (bus.mem_ready) state <= DECODE;
        DECODE:
          case (bus.opcode)
            4'd0:       state <= EXEC;
            4'd1:       state <= ADDIEX;
            4'd2, 4'd3: state <= MEMADR;
            4'd4, 4'd5: state <= BRANCH;
            4'd6:       state <= JUMP;
            4'd7:       state <= HALT;
            default:    state <= FETCH;
          endcase
        MEMADR: state <= (bus.opcode == 4'd3) ? MEMWR : MEMRD;
        MEMRD:  if (bus.mem_ready) state <= MEMWB;
        MEMWR:  if (bus.mem_ready) state <= FETCH;
        EXEC, ADDIEX: state <= ALUWB;
        HALT:   state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end

  // Moore decode; FETCH and BRANCH enables additionally qualify on inputs.
  always_comb begin
    bus.pc_write   = 1'b0;
    bus.ir_write   = 1'b0;
    bus.iord       = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.reg_write  = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.alu_op     = ALU_ADD;
    bus.pc_source  = 2'b00;
    bus.illegal_op = 1'b0;
    bus.halted     = 1'b0;
    case (state)
      FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
      end
      DECODE: begin
        bus.alu_src_b  = 2'b10;
        bus.illegal_op = bus.opcode[3];
      end
      MEMADR, ADDIEX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
      end
      MEMRD: begin
        bus.mem_read = 1'b1;
        bus.iord     = 1'b1;
      end
      MEMWB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      MEMWR: begin
        bus.mem_write = 1'b1;
        bus.iord      = 1'b1;
      end
      EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = ALU_FUNCT;
      end
      ALUWB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = (bus.opcode == 4'd0);
      end
      BRANCH: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = ALU_SUB;
        bus.pc_source = 2'b01;
        bus.pc_write  = ((bus.opcode == 4'd4) &&  bus.zero) ||
                        ((bus.opcode == 4'd5) && !bus.zero);
      end
      JUMP: begin
        bus.pc_source = 2'b10;
        bus.pc_write  = 1'b1;
      end
      HALT:    bus.halted = 1'b1;
      default: ;
    endcase
    if (reset) begin
      bus.pc_write   = 1'b0;
      bus.ir_write   = 1'b0;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.reg_write  = 1'b0;
      bus.illegal_op = 1'b0;
    end
  end

  assign bus.state_out   = state;
  assign bus.cycle_count = cycle_q;
  assign bus.instr_count = instr_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: inputs change and outputs are
// checked just after the falling edge.
module tb_multicycle_control;
  logic clock = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  multicycle_control_if #(.CNT_W(16)) bus();
  multicycle_control #(.CNT_W(16)) dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  function automatic logic [31:0] strobes();
    return {27'd0, bus.pc_write, bus.ir_write, bus.mem_read, bus.mem_write, bus.reg_write};
  endfunction

  typedef struct { logic [3:0] op; logic z; logic pw; } br_t;
  br_t br_tab[4];

  initial begin
    br_tab[0] = '{4'd4, 1'b1, 1'b1};
    br_tab[1] = '{4'd4, 1'b0, 1'b0};
    br_tab[2] = '{4'd5, 1'b0, 1'b1};
    br_tab[3] = '{4'd5, 1'b1, 1'b0};

    reset = 1'b1; bus.opcode = 4'd0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    repeat (5) @(posedge clock);
    tick();
    chk("rst_strobes", strobes(), 0);
    chk("rst_state", bus.state_out, 0);
    chk("rst_cyc", bus.cycle_count, 0);
    chk("rst_ins", bus.instr_count, 0);
    chk("rst_halted", bus.halted, 0);
    chk("rst_illegal", bus.illegal_op, 0);

    // R-type: 0,1,6,7,0
    reset = 1'b0; #1;
    chk("r_st0", bus.state_out, 0);
    chk("r_fetch_strobes", strobes(), 32'b11100);
    chk("r_fetch_srcb", bus.alu_src_b, 2'b01);
    tick(); chk("r_st1", bus.state_out, 1);
    chk("r_dec_srcb", bus.alu_src_b, 2'b10);
    chk("r_dec_rw", bus.reg_write, 0);
    tick(); chk("r_st6", bus.state_out, 6);
    chk("r_exec_aluop", bus.alu_op, 3'b010);
    chk("r_exec_srca", bus.alu_src_a, 1);
    tick(); chk("r_st7", bus.state_out, 7);
    chk("r_wb_rw", bus.reg_write, 1);
    chk("r_wb_dst", bus.reg_dst, 1);
    tick(); chk("r_st0b", bus.state_out, 0);
    chk("r_ins", bus.instr_count, 1);
    chk("r_cyc", bus.cycle_count, 4);
    chk("r_rw_off", bus.reg_write, 0);

    // LW with three wait cycles in MEMRD
    bus.opcode = 4'd2;
    tick(); chk("lw_st1", bus.state_out, 1);
    tick(); chk("lw_st2", bus.state_out, 2);
    tick(); bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("lw_wait_st", bus.state_out, 3);
      chk("lw_wait_rd", bus.mem_read, 1);
      chk("lw_wait_iord", bus.iord, 1);
      tick();
    end
    bus.mem_ready = 1'b1; #1;
    chk("lw_st3_last", bus.state_out, 3);
    chk("lw_rd_last", bus.mem_read, 1);
    tick(); chk("lw_st4", bus.state_out, 4);
    chk("lw_m2r", bus.mem_to_reg, 1);
    chk("lw_rw", bus.reg_write, 1);
    chk("lw_dst", bus.reg_dst, 0);
    tick(); chk("lw_st0", bus.state_out, 0);
    chk("lw_ins", bus.instr_count, 2);
    chk("lw_cyc", bus.cycle_count, 12);

    // BEQ / BNE
    for (int i = 0; i < 4; i++) begin
      bus.opcode = br_tab[i].op; bus.zero = br_tab[i].z;
      tick(); chk("br_st1", bus.state_out, 1);
      tick(); chk("br_st8", bus.state_out, 8);
      chk("br_pw", bus.pc_write, br_tab[i].pw);
      chk("br_psrc", bus.pc_source, 2'b01);
      chk("br_aluop", bus.alu_op, 3'b001);
      tick(); chk("br_st0", bus.state_out, 0);
      chk("br_ins", bus.instr_count, 3 + i);
    end

    // Illegal opcode
    bus.opcode = 4'd9; bus.zero = 1'b0; #1;
    chk("ill_pre", bus.illegal_op, 0);
    tick(); chk("ill_st1", bus.state_out, 1);
    chk("ill_pulse", bus.illegal_op, 1);
    chk("ill_cyc_a", bus.cycle_count, 25);
    tick(); chk("ill_st0", bus.state_out, 0);
    chk("ill_off", bus.illegal_op, 0);
    chk("ill_ins", bus.instr_count, 6);
    chk("ill_cyc_b", bus.cycle_count, 26);

    // Jump
    bus.opcode = 4'd6;
    tick(); chk("j_st1", bus.state_out, 1);
    tick(); chk("j_st9", bus.state_out, 9);
    chk("j_pw", bus.pc_write, 1);
    chk("j_psrc", bus.pc_source, 2'b10);
    tick(); chk("j_st0", bus.state_out, 0);
    chk("j_ins", bus.instr_count, 7);

    // Halt held for 20 cycles
    bus.opcode = 4'd7;
    tick(); chk("h_st1", bus.state_out, 1);
    tick();
    for (int i = 0; i < 20; i++) begin
      chk("h_st", bus.state_out, 11);
      chk("h_halted", bus.halted, 1);
      chk("h_strobes", strobes(), 0);
      chk("h_ins", bus.instr_count, 8);
      tick();
    end
    chk("h_cyc", bus.cycle_count, 51);
    reset = 1'b1; #1;
    chk("h_rst_strobes", strobes(), 0);
    tick();
    chk("h_rst_st", bus.state_out, 0);
    chk("h_rst_halted", bus.halted, 0);
    chk("h_rst_cyc", bus.cycle_count, 0);
    chk("h_rst_ins", bus.instr_count, 0);

    // SW completing normally (4 cycles)
    reset = 1'b0; bus.opcode = 4'd3; bus.mem_ready = 1'b1; #1;
    tick(); chk("sw_st1", bus.state_out, 1);
    tick(); chk("sw_st2", bus.state_out, 2);
    chk("sw_adr_srca", bus.alu_src_a, 1);
    tick(); chk("sw_st5", bus.state_out, 5);
    chk("sw_mw", bus.mem_write, 1);
    chk("sw_iord", bus.iord, 1);
    tick(); chk("sw_st0", bus.state_out, 0);
    chk("sw_ins", bus.instr_count, 1);
    chk("sw_cyc", bus.cycle_count, 4);

    // SW stalled, then reset mid-wait
    tick(); tick(); tick();
    chk("swr_st5", bus.state_out, 5);
    bus.mem_ready = 1'b0;
    tick(); chk("swr_hold_st", bus.state_out, 5);
    chk("swr_hold_mw", bus.mem_write, 1);
    tick(); chk("swr_hold_mw2", bus.mem_write, 1);
    reset = 1'b1; #1;
    chk("swr_rst_mw", bus.mem_write, 0);
    chk("swr_rst_st", bus.state_out, 5);
    tick(); reset = 1'b0; #1;
    chk("swr_st0", bus.state_out, 0);
    chk("swr_cyc", bus.cycle_count, 0);
    chk("swr_ins", bus.instr_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
